// File: rtl/sched_pkg.sv
// Shared definitions for the weighted buffer scheduler: mode encodings,
// forced-mode encodings and width helpers used by the top, the interface
// and the per-channel FIFO.
package sched_pkg;

   typedef enum logic {
      MODE_LAT = 1'b0,
      MODE_REL = 1'b1
   } mode_e;

   localparam logic [1:0] FORCE_AUTO = 2'b00;
   localparam logic [1:0] FORCE_LAT  = 2'b01;
   localparam logic [1:0] FORCE_REL  = 2'b10;

   // Bits needed to hold a count from 0 to depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Bits needed to index n items, never less than one.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Bits for a weighted score whose largest weight is num_ch and whose
   // worst case is every channel full: depth * (1 + 2 + ... + num_ch).
   function automatic int score_width(input int num_ch, input int depth);
      return $clog2(depth * num_ch * (num_ch + 1) / 2 + 1);
   endfunction

endpackage

// File: rtl/weighted_buffer_scheduler_if.sv
// Producer/display-side bundle of the weighted buffer scheduler. The
// scheduler uses the slave view; whoever drives the channels and reads the
// display uses the master view.
interface weighted_buffer_scheduler_if #(
   parameter int NUM_CH = 4,
   parameter int DEPTH  = 6,
   parameter int DATA_W = 2
);
   localparam int CNT_W = sched_pkg::cnt_width(DEPTH);
   localparam int CH_W  = sched_pkg::idx_width(NUM_CH);

   logic [NUM_CH-1:0]        in_valid;
   logic [NUM_CH*DATA_W-1:0] in_data;
   logic [NUM_CH-1:0]        in_ready;
   logic [1:0]               mode_force;
   logic [NUM_CH*CNT_W-1:0]  occupancy;
   logic                     mode;
   logic [DATA_W-1:0]        disp;
   logic [CH_W-1:0]          disp_ch;
   logic                     disp_valid;

   modport master (
      output in_valid, in_data, mode_force,
      input  in_ready, occupancy, mode, disp, disp_ch, disp_valid
   );

   modport slave (
      input  in_valid, in_data, mode_force,
      output in_ready, occupancy, mode, disp, disp_ch, disp_valid
   );

endinterface

// File: rtl/chan_fifo.sv
// One channel's circular FIFO. Pointers wrap explicitly at DEPTH so the
// depth does not have to be a power of two. A push while full and a pop
// while empty are ignored.
module chan_fifo #(
   parameter int   DEPTH  = 6,
   parameter int   DATA_W = 2,
   localparam int  CNT_W  = sched_pkg::cnt_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);
   localparam int PTR_W = sched_pkg::idx_width(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              push_ok;
   logic              pop_ok;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign data_out = mem[rd_ptr];

   // Storage is not reset; the pointers and count alone define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= data_in;
   end

   // Pointer and count bookkeeping; a simultaneous push and pop keeps the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= next_ptr(wr_ptr);
         if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/weighted_buffer_scheduler.sv
// Multi-channel buffering scheduler. Each channel has its own FIFO; on every
// prescaler tick one non-empty channel is chosen from weighted occupancy
// scores and its head entry is presented on the display outputs.
module weighted_buffer_scheduler #(
   parameter int NUM_CH   = 4,
   parameter int DEPTH    = 6,
   parameter int DATA_W   = 2,
   parameter int TICK_DIV = 75000000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   weighted_buffer_scheduler_if.slave   bus
);
   import sched_pkg::*;

   localparam int CNT_W   = cnt_width(DEPTH);
   localparam int CH_W    = idx_width(NUM_CH);
   localparam int SCORE_W = score_width(NUM_CH, DEPTH);
   localparam int PRE_W   = idx_width(TICK_DIV);

   logic [PRE_W-1:0]        presc;
   logic                    tick;
   logic [CNT_W-1:0]        cnt  [NUM_CH];
   logic [DATA_W-1:0]       head [NUM_CH];
   logic [NUM_CH-1:0]       full;
   logic [NUM_CH-1:0]       empty;
   logic [NUM_CH-1:0]       pop;
   logic [NUM_CH*CNT_W-1:0] occ_flat;
   logic [SCORE_W-1:0]      rea;
   logic [SCORE_W-1:0]      lat;
   mode_e                   sel_mode;
   logic [CH_W-1:0]         sel;
   logic [CNT_W-1:0]        best;
   logic                    do_pop;

   mode_e                   mode_q;
   logic [DATA_W-1:0]       disp_q;
   logic [CH_W-1:0]         disp_ch_q;
   logic                    disp_valid_q;

   assign tick   = (presc == PRE_W'(TICK_DIV - 1));
   assign do_pop = tick && !(&empty);

   // Free-running prescaler that produces one tick every TICK_DIV cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    presc <= '0;
      else if (tick) presc <= '0;
      else           presc <= presc + PRE_W'(1);
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      chan_fifo #(
         .DEPTH  (DEPTH),
         .DATA_W (DATA_W)
      ) u_fifo (
         .clk      (clk),
         .rst_n    (rst_n),
         .push     (bus.in_valid[g]),
         .pop      (pop[g]),
         .data_in  (bus.in_data[g*DATA_W +: DATA_W]),
         .data_out (head[g]),
         .count    (cnt[g]),
         .full     (full[g]),
         .empty    (empty[g])
      );
   end

   // Flatten per-channel counts for the occupancy bus.
   always_comb begin
      occ_flat = '0;
      for (int i = 0; i < NUM_CH; i++) occ_flat[i*CNT_W +: CNT_W] = cnt[i];
   end

   // Weighted scores: reliability favours high channels, latency low channels.
   always_comb begin
      rea = '0;
      lat = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         rea = rea + SCORE_W'(i + 1) * SCORE_W'(cnt[i]);
         lat = lat + SCORE_W'(NUM_CH - i) * SCORE_W'(cnt[i]);
      end
   end

   // Mode for this cycle: forced encodings win, otherwise compare scores.
   always_comb begin
      case (bus.mode_force)
         FORCE_LAT:  sel_mode = MODE_LAT;
         FORCE_REL:  sel_mode = MODE_REL;
         FORCE_AUTO: sel_mode = (rea >= lat) ? MODE_REL : MODE_LAT;
         default:    sel_mode = (rea >= lat) ? MODE_REL : MODE_LAT;
      endcase
   end

   // Fullest non-empty channel; ties go low in latency mode, high in reliability.
   always_comb begin
      sel  = '0;
      best = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!empty[i] && (cnt[i] > best || (sel_mode == MODE_REL && cnt[i] == best))) begin
            sel  = CH_W'(i);
            best = cnt[i];
         end
      end
   end

   // Pop strobe for the chosen channel on a tick with something to send.
   always_comb begin
      pop = '0;
      if (do_pop) pop[sel] = 1'b1;
   end

   // Registered display outputs; they hold when a tick finds nothing to pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q       <= MODE_LAT;
         disp_q       <= '0;
         disp_ch_q    <= '0;
         disp_valid_q <= 1'b0;
      end else begin
         disp_valid_q <= 1'b0;
         if (do_pop) begin
            mode_q       <= sel_mode;
            disp_q       <= head[sel];
            disp_ch_q    <= sel;
            disp_valid_q <= 1'b1;
         end
      end
   end

   assign bus.in_ready   = ~full;
   assign bus.occupancy  = occ_flat;
   assign bus.mode       = mode_q;
   assign bus.disp       = disp_q;
   assign bus.disp_ch    = disp_ch_q;
   assign bus.disp_valid = disp_valid_q;

endmodule

// File: tb/tb_weighted_buffer_scheduler.sv
// Directed self-checking bench for weighted_buffer_scheduler with a short
// tick period so several scheduling decisions fit in a few dozen cycles.
module tb_weighted_buffer_scheduler;

   localparam int NUM_CH   = 4;
   localparam int DEPTH    = 6;
   localparam int DATA_W   = 2;
   localparam int TICK_DIV = 4;
   localparam int CNT_W    = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   weighted_buffer_scheduler_if #(
      .NUM_CH (NUM_CH),
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) bus ();

   weighted_buffer_scheduler #(
      .NUM_CH   (NUM_CH),
      .DEPTH    (DEPTH),
      .DATA_W   (DATA_W),
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [CNT_W-1:0] occ(input int ch);
      return bus.occupancy[ch*CNT_W +: CNT_W];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [3:0] mask, input logic [1:0] d0,
                                 input logic [1:0] d1, input logic [1:0] d2,
                                 input logic [1:0] d3);
      bus.in_valid = mask;
      bus.in_data  = {d3, d2, d1, d0};
      step();
      bus.in_valid = '0;
   endtask

   task automatic reset_dut();
      rst_n          = 1'b0;
      bus.in_valid   = '0;
      bus.in_data    = '0;
      bus.mode_force = 2'b00;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic wait_pop(input string tag, input logic [1:0] exp_d, input logic [1:0] exp_ch);
      int  n = 0;
      bit  seen = 1'b0;
      while (!seen && n < 2 * TICK_DIV) begin
         step();
         n++;
         if (bus.disp_valid) seen = 1'b1;
      end
      check_output({tag, "_seen"}, 32'(seen), 32'd1);
      check_output({tag, "_disp"}, 32'(bus.disp), 32'(exp_d));
      check_output({tag, "_ch"}, 32'(bus.disp_ch), 32'(exp_ch));
   endtask

   initial begin
      int valid_seen;

      bus.in_valid   = '0;
      bus.in_data    = '0;
      bus.mode_force = 2'b00;
      reset_dut();

      check_output("rst_occ", 32'(bus.occupancy), 32'd0);
      check_output("rst_ready", 32'(bus.in_ready), 32'hF);
      check_output("rst_valid", 32'(bus.disp_valid), 32'd0);

      // Latency auto: ch0 = 1,2,3 and ch3 = 1 -> rea 7, lat 13.
      apply_stimulus(4'b1001, 2'd1, 2'd0, 2'd0, 2'd1);
      apply_stimulus(4'b0001, 2'd2, 2'd0, 2'd0, 2'd0);
      apply_stimulus(4'b0001, 2'd3, 2'd0, 2'd0, 2'd0);
      check_output("lat_prevalid", 32'(bus.disp_valid), 32'd0);
      step();
      check_output("lat_valid", 32'(bus.disp_valid), 32'd1);
      check_output("lat_disp", 32'(bus.disp), 32'd1);
      check_output("lat_ch", 32'(bus.disp_ch), 32'd0);
      check_output("lat_mode", 32'(bus.mode), 32'd0);
      check_output("lat_occ0", 32'(occ(0)), 32'd2);
      check_output("lat_occ3", 32'(occ(3)), 32'd1);
      step();
      check_output("lat_pulse", 32'(bus.disp_valid), 32'd0);

      // Asynchronous reset mid-period wipes buffered data and outputs.
      step();
      rst_n = 1'b0;
      #1;
      check_output("arst_occ", 32'(bus.occupancy), 32'd0);
      check_output("arst_ready", 32'(bus.in_ready), 32'hF);
      check_output("arst_disp", 32'(bus.disp), 32'd0);
      check_output("arst_ch", 32'(bus.disp_ch), 32'd0);
      check_output("arst_mode", 32'(bus.mode), 32'd0);
      check_output("arst_valid", 32'(bus.disp_valid), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      apply_stimulus(4'b0010, 2'd0, 2'd2, 2'd0, 2'd0);
      step();
      step();
      check_output("tick_early", 32'(bus.disp_valid), 32'd0);
      step();
      check_output("tick_valid", 32'(bus.disp_valid), 32'd1);
      check_output("tick_disp", 32'(bus.disp), 32'd2);
      check_output("tick_ch", 32'(bus.disp_ch), 32'd1);
      check_output("tick_mode", 32'(bus.mode), 32'd0);

      // Reliability auto: ch0 = 1 entry, ch3 = 2 entries -> rea 9, lat 6.
      reset_dut();
      apply_stimulus(4'b1001, 2'd1, 2'd0, 2'd0, 2'd2);
      apply_stimulus(4'b1000, 2'd0, 2'd0, 2'd0, 2'd3);
      step();
      step();
      check_output("rel_valid", 32'(bus.disp_valid), 32'd1);
      check_output("rel_disp", 32'(bus.disp), 32'd2);
      check_output("rel_ch", 32'(bus.disp_ch), 32'd3);
      check_output("rel_mode", 32'(bus.mode), 32'd1);
      check_output("rel_occ3", 32'(occ(3)), 32'd1);

      // Tie: ch1 = 2, ch2 = 2 -> scores equal -> reliability, highest index.
      // A push to ch0 in the tick cycle must land regardless of the pop.
      reset_dut();
      apply_stimulus(4'b0110, 2'd0, 2'd1, 2'd3, 2'd0);
      apply_stimulus(4'b0110, 2'd0, 2'd2, 2'd0, 2'd0);
      step();
      apply_stimulus(4'b0001, 2'd1, 2'd0, 2'd0, 2'd0);
      check_output("tie_ch", 32'(bus.disp_ch), 32'd2);
      check_output("tie_disp", 32'(bus.disp), 32'd3);
      check_output("tie_mode", 32'(bus.mode), 32'd1);
      check_output("tie_occ0", 32'(occ(0)), 32'd1);
      check_output("tie_occ1", 32'(occ(1)), 32'd2);
      check_output("tie_occ2", 32'(occ(2)), 32'd1);

      // Same tie with latency forced: lowest index wins.
      reset_dut();
      bus.mode_force = 2'b01;
      apply_stimulus(4'b0110, 2'd0, 2'd1, 2'd3, 2'd0);
      apply_stimulus(4'b0110, 2'd0, 2'd2, 2'd0, 2'd0);
      step();
      step();
      check_output("frc_ch", 32'(bus.disp_ch), 32'd1);
      check_output("frc_disp", 32'(bus.disp), 32'd1);
      check_output("frc_mode", 32'(bus.mode), 32'd0);
      bus.mode_force = 2'b00;

      // Fill ch0 with payload k%4 at edge k; ticks pop at edges 4 and 8.
      reset_dut();
      for (int k = 1; k <= 8; k++) begin
         apply_stimulus(4'b0001, 2'(k % 4), 2'd0, 2'd0, 2'd0);
         if (k == 4) begin
            check_output("conc_occ0", 32'(occ(0)), 32'd3);
            check_output("conc_disp", 32'(bus.disp), 32'd1);
         end
         if (k == 7) begin
            check_output("full_occ0", 32'(occ(0)), 32'd6);
            check_output("full_ready", 32'(bus.in_ready), 32'hE);
         end
         if (k == 8) begin
            check_output("ovf_occ0", 32'(occ(0)), 32'd5);
            check_output("ovf_disp", 32'(bus.disp), 32'd2);
         end
      end
      wait_pop("ord3", 2'd3, 2'd0);
      wait_pop("ord4", 2'd0, 2'd0);
      wait_pop("ord5", 2'd1, 2'd0);
      wait_pop("ord6", 2'd2, 2'd0);
      wait_pop("ord7", 2'd3, 2'd0);
      check_output("drain_occ", 32'(bus.occupancy), 32'd0);

      // Empty: one pop from ch2, then three ticks with nothing buffered.
      reset_dut();
      apply_stimulus(4'b0100, 2'd0, 2'd0, 2'd3, 2'd0);
      step();
      step();
      step();
      check_output("emp_first", 32'(bus.disp_valid), 32'd1);
      valid_seen = 0;
      for (int c = 0; c < 3 * TICK_DIV + 1; c++) begin
         step();
         if (bus.disp_valid) valid_seen++;
      end
      check_output("emp_novalid", 32'(valid_seen), 32'd0);
      check_output("emp_disp", 32'(bus.disp), 32'd3);
      check_output("emp_ch", 32'(bus.disp_ch), 32'd2);
      check_output("emp_mode", 32'(bus.mode), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
